// File: rtl/star_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : star_pkg
//  Purpose  : Shared definitions for the star shader. Holds the colour level
//             width, the default brightness floor for a lit star and the
//             triangle-wave brightness function.
//  Revision : 1.0  initial release
// ============================================================================
package star_pkg;

    localparam int c_level_w = 4;

    typedef logic [c_level_w-1:0] level_t;

    localparam level_t c_min_level_default = 4'd3;

    // Triangle wave over a 16-step phase: 1,3,..,15 on the rising half,
    // then 15,13,..,1 on the falling half. For phase = 8+q the value
    // 31-2*phase reduces to 15-2q, which is the bitwise inverse of 2q.
    function automatic level_t tri_wave(input level_t phase);
        level_t r;
        if (phase[3]) begin
            r = ~{phase[2:0], 1'b0};
        end else begin
            r = {phase[2:0], 1'b1};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vsync_frame_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vsync_frame_counter
//  Purpose  : Detects the inactive-to-active edge of the stage-1 vsync and
//             counts frames. Only the top four counter bits (the twinkle
//             phase base) leave the block.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             i_vsync_s1    - vsync already registered by pipeline stage 1
//             o_frame_hi    - frame_cnt[MSB-:4]
//  Revision : 1.0  initial release
// ============================================================================
module vsync_frame_counter #(
    parameter int TWINKLE_SHIFT = 2,
    parameter bit VS_ACTIVE     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_vsync_s1,
    output logic [3:0] o_frame_hi
);

    localparam int c_cnt_w = 4 + TWINKLE_SHIFT;

    logic               r_vs_prev_q;
    logic               w_vs_prev_d;
    logic [c_cnt_w-1:0] r_frame_cnt_q;
    logic [c_cnt_w-1:0] w_frame_cnt_d;
    logic               w_frame_tick;

    always_comb begin
        w_frame_tick  = (i_vsync_s1 == VS_ACTIVE) && (r_vs_prev_q != VS_ACTIVE);
        w_vs_prev_d   = i_vsync_s1;
        w_frame_cnt_d = r_frame_cnt_q;
        if (w_frame_tick) begin
            // Natural wrap from all-ones back to zero.
            w_frame_cnt_d = r_frame_cnt_q + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Inactive history lets an active vsync right after reset count.
            r_vs_prev_q   <= ~VS_ACTIVE;
            r_frame_cnt_q <= '0;
        end else begin
            r_vs_prev_q   <= w_vs_prev_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    assign o_frame_hi = r_frame_cnt_q[c_cnt_w-1 -: 4];

endmodule
`default_nettype wire

// File: rtl/star_shader.sv
`default_nettype none
// ============================================================================
//  Module   : star_shader
//  Purpose  : Two-stage pixel pipeline that shades starfield pixels with a
//             per-star twinkling brightness and forwards the syncs aligned
//             with the colour.
//  Ports    : clk, reset               - pixel clock, sync active-high reset
//             display_on, hsync, vsync - from the timing generator
//             star_on, star_color      - star present / {R,G,B} enables
//             star_phase               - per-star twinkle offset
//             vgaRed/Green/Blue        - registered 4-bit colour
//             Hsync, Vsync             - registered syncs, 2 clk latency
//  Revision : 1.0  initial release
// ============================================================================
module star_shader
    import star_pkg::*;
#(
    parameter int     TWINKLE_SHIFT = 2,
    parameter level_t MIN_LEVEL     = c_min_level_default,
    parameter bit     HS_ACTIVE     = 1'b1,
    parameter bit     VS_ACTIVE     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_on,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       star_on,
    input  logic [2:0] star_color,
    input  logic [3:0] star_phase,
    output logic [3:0] vgaRed,
    output logic [3:0] vgaGreen,
    output logic [3:0] vgaBlue,
    output logic       Hsync,
    output logic       Vsync
);

    // Stage 1: registered inputs
    logic       r_display_on_s1_q, r_star_on_s1_q, r_hsync_s1_q, r_vsync_s1_q;
    logic [2:0] r_star_color_s1_q;
    logic [3:0] r_star_phase_s1_q;

    // Stage 2: registered outputs
    level_t r_red_q, r_green_q, r_blue_q;
    level_t w_red_d, w_green_d, w_blue_d;
    logic   r_hsync_s2_q, r_vsync_s2_q;
    logic   w_hsync_s2_d, w_vsync_s2_d;

    logic [3:0] w_frame_hi;
    level_t     w_phase;
    level_t     w_tri;
    level_t     w_level;
    logic       w_lit;

    vsync_frame_counter #(
        .TWINKLE_SHIFT (TWINKLE_SHIFT),
        .VS_ACTIVE     (VS_ACTIVE)
    ) u_frame_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_vsync_s1 (r_vsync_s1_q),
        .o_frame_hi (w_frame_hi)
    );

    always_comb begin
        // The frame counter seen here is the pre-tick value; its update
        // lands on the same edge that registers this pixel's colour.
        w_phase = w_frame_hi + r_star_phase_s1_q;
        w_tri   = tri_wave(w_phase);
        w_level = (w_tri < MIN_LEVEL) ? MIN_LEVEL : w_tri;
        w_lit   = r_display_on_s1_q && r_star_on_s1_q;

        w_red_d      = (w_lit && r_star_color_s1_q[2]) ? w_level : '0;
        w_green_d    = (w_lit && r_star_color_s1_q[1]) ? w_level : '0;
        w_blue_d     = (w_lit && r_star_color_s1_q[0]) ? w_level : '0;
        w_hsync_s2_d = r_hsync_s1_q;
        w_vsync_s2_d = r_vsync_s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_display_on_s1_q <= 1'b0;
            r_star_on_s1_q    <= 1'b0;
            r_star_color_s1_q <= '0;
            r_star_phase_s1_q <= '0;
            r_hsync_s1_q      <= ~HS_ACTIVE;
            r_vsync_s1_q      <= ~VS_ACTIVE;
            r_red_q           <= '0;
            r_green_q         <= '0;
            r_blue_q          <= '0;
            r_hsync_s2_q      <= ~HS_ACTIVE;
            r_vsync_s2_q      <= ~VS_ACTIVE;
        end else begin
            r_display_on_s1_q <= display_on;
            r_star_on_s1_q    <= star_on;
            r_star_color_s1_q <= star_color;
            r_star_phase_s1_q <= star_phase;
            r_hsync_s1_q      <= hsync;
            r_vsync_s1_q      <= vsync;
            r_red_q           <= w_red_d;
            r_green_q         <= w_green_d;
            r_blue_q          <= w_blue_d;
            r_hsync_s2_q      <= w_hsync_s2_d;
            r_vsync_s2_q      <= w_vsync_s2_d;
        end
    end

    assign vgaRed   = r_red_q;
    assign vgaGreen = r_green_q;
    assign vgaBlue  = r_blue_q;
    assign Hsync    = r_hsync_s2_q;
    assign Vsync    = r_vsync_s2_q;

endmodule
`default_nettype wire

// File: tb/tb_star_shader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_star_shader
//  Purpose  : Self-checking bench for star_shader. Inputs are applied on the
//             falling edge; a frame-level model predicts each pixel and the
//             prediction is compared two cycles later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_star_shader;

    logic       clk = 1'b0;
    logic       reset;
    logic       display_on, hsync, vsync, star_on;
    logic [2:0] star_color;
    logic [3:0] star_phase;
    logic [3:0] vgaRed, vgaGreen, vgaBlue;
    logic       Hsync, Vsync;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [11:0] rgb;
        logic [1:0]  sync;
    } exp_t;

    exp_t q[$];
    int   m_cnt;      // frame counter, 0..63
    bit   m_prev_vs;  // previously sampled vsync

    star_shader dut (
        .clk        (clk),
        .reset      (reset),
        .display_on (display_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .star_on    (star_on),
        .star_color (star_color),
        .star_phase (star_phase),
        .vgaRed     (vgaRed),
        .vgaGreen   (vgaGreen),
        .vgaBlue    (vgaBlue),
        .Hsync      (Hsync),
        .Vsync      (Vsync)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Brightness straight from the rules: phase from the top four frame
    // bits plus the star offset, triangle 1..15..1, floored at 3.
    function automatic int model_level(input int cnt, input int sp);
        int ph, t;
        ph = ((cnt / 4) + sp) % 16;
        t  = (ph < 8) ? (2 * ph + 1) : (31 - 2 * ph);
        return (t < 3) ? 3 : t;
    endfunction

    task automatic step(input bit rst, input bit disp, input bit on,
                        input logic [2:0] col, input logic [3:0] sp,
                        input bit hs, input bit vs);
        exp_t e, er;
        int   lv;
        @(negedge clk);
        if (q.size() == 2) begin
            e = q.pop_front();
            check("rgb",  32'(e.rgb), 32'({vgaRed, vgaGreen, vgaBlue}));
            check("sync", 32'(e.sync), 32'({Hsync, Vsync}));
        end
        reset = rst; display_on = disp; star_on = on;
        star_color = col; star_phase = sp; hsync = hs; vsync = vs;
        er.rgb  = '0;
        er.sync = 2'b00;
        if (rst) begin
            if (q.size() == 1) q[0] = er;
            q.push_back(er);
            m_cnt     = 0;
            m_prev_vs = 1'b0;
        end else begin
            lv = (disp && on) ? model_level(m_cnt, int'(sp)) : 0;
            e.rgb  = {col[2] ? 4'(lv) : 4'd0, col[1] ? 4'(lv) : 4'd0,
                      col[0] ? 4'(lv) : 4'd0};
            e.sync = {hs, vs};
            q.push_back(e);
            if (vs && !m_prev_vs) m_cnt = (m_cnt + 1) % 64;
            m_prev_vs = vs;
        end
    endtask

    initial begin
        m_cnt = 0; m_prev_vs = 1'b0;
        reset = 1'b1; display_on = 1'b0; star_on = 1'b0;
        star_color = '0; star_phase = '0; hsync = 1'b0; vsync = 1'b0;

        repeat (3) step(1, 0, 0, 3'b000, 4'd0, 0, 0);
        // Floor level at phase 0, single red channel at the peak, blanking
        step(0, 1, 1, 3'b111, 4'd0, 0, 0);
        step(0, 1, 1, 3'b100, 4'd7, 0, 0);
        step(0, 0, 1, 3'b111, 4'd7, 0, 0);
        step(0, 1, 0, 3'b111, 4'd7, 0, 0);
        // Sync pass-through pattern
        begin
            bit [4:0] pat;
            pat = 5'b10110;
            for (int i = 4; i >= 0; i--) step(0, 0, 0, 3'b000, 4'd0, pat[i], pat[i]);
        end
        // 64 frames with a lit star: phase advances every 4 frames, wraps at 64
        for (int f = 0; f < 64; f++) begin
            step(0, 1, 1, 3'b111, 4'd0, 0, 1);
            step(0, 1, 1, 3'b111, 4'd0, 0, 0);
        end
        // Mid-frame reset with a non-zero counter
        for (int f = 0; f < 9; f++) begin
            step(0, 1, 1, 3'b011, 4'd2, 1, 1);
            step(0, 1, 1, 3'b011, 4'd2, 1, 0);
        end
        step(1, 1, 1, 3'b111, 4'd5, 1, 1);
        step(0, 1, 1, 3'b111, 4'd0, 1, 1);
        step(0, 1, 1, 3'b111, 4'd0, 0, 0);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 3'($urandom), 4'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0));
        end
        repeat (2) step(0, 0, 0, 3'b000, 4'd0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/star_shader.md
STAR_SHADER -- requirements
Module: star_shader

Interface
REQ-001 SHALL have parameter TWINKLE_SHIFT, default 2, log2 of frames per twinkle phase step.
REQ-002 SHALL have parameter MIN_LEVEL, default 4'd3, floor intensity for a lit star.
REQ-003 SHALL have parameter HS_ACTIVE, default 1'b1, active level of hsync.
REQ-004 SHALL have parameter VS_ACTIVE, default 1'b1, active level of vsync.
REQ-005 SHALL have port clk, input, 1, 25 MHz pixel clock; the block has one clock.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port display_on, input, 1, visible-area flag from the timing generator.
REQ-008 SHALL have ports hsync and vsync, input, 1 each, raw syncs from the timing generator.
REQ-009 SHALL have port star_on, input, 1, star present at the current pixel.
REQ-010 SHALL have port star_color, input, 3, {R,G,B} enable bits.
REQ-011 SHALL have port star_phase, input, 4, per-star twinkle phase offset from the LFSR.
REQ-012 SHALL have ports vgaRed, vgaGreen, vgaBlue, output, 4 each, registered pixel colour.
REQ-013 SHALL have ports Hsync and Vsync, output, 1 each, registered syncs aligned with colour.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers all inputs; stage 2 registers all outputs; latency exactly 2 clk for colour, Hsync and Vsync.
REQ-015 SHALL pass hsync/vsync through both stages unmodified; no polarity change.
REQ-016 SHALL detect frame_tick when stage-1 vsync goes from !VS_ACTIVE to VS_ACTIVE (one-cycle pulse).
REQ-017 SHALL keep frame_cnt, width 4+TWINKLE_SHIFT, incremented on each frame_tick, wrapping from all-ones to 0.
REQ-018 SHALL compute phase = frame_cnt[MSB-:4] + star_phase (stage-1 value), modulo 16.
REQ-019 SHALL compute tri = 2*phase+1 for phase 0..7, 31-2*phase for phase 8..15 (range 1..15, 4-bit).
REQ-020 SHALL compute level = max(tri, MIN_LEVEL).
REQ-021 SHALL drive each channel to level when display_on, star_on and its star_color bit are all set in stage 1; otherwise 4'd0.
REQ-022 SHALL output black whenever display_on=0, including when star_on=1.
REQ-023 SHALL use the frame_cnt value held before a frame_tick for the pixel coinciding with that tick (counter update visible one cycle later).

Reset
REQ-024 SHALL clear frame_cnt, all colour registers and display_on/star_on pipeline bits to 0 on reset.
REQ-025 SHALL load Hsync/Vsync pipeline registers with !HS_ACTIVE / !VS_ACTIVE on reset.
REQ-026 SHALL load the vsync edge-history register with !VS_ACTIVE, so vsync active in the first post-reset cycle counts as a tick.
REQ-027 SHALL let reset asserted mid-frame override all logic in the same edge; pipeline refills in 2 clk after release.

Structure
REQ-028 SHALL place level width, tri function and MIN_LEVEL default in shared package star_pkg.
REQ-029 SHALL implement edge detect plus frame_cnt in sub-module vsync_frame_counter.
REQ-030 SHALL contain no combinational path from any input to any output.

Verification
REQ-031 Reset then star_on=1, display_on=1, star_color=3'b111, star_phase=0, frame_cnt=0 -> two cycles later all channels 4'd3 (tri=1 floored).
REQ-032 star_phase=7, frame_cnt=0, star_color=3'b100 -> vgaRed=15, vgaGreen=0, vgaBlue=0 after 2 clk.
REQ-033 Toggle hsync/vsync pattern 1,0,1,1,0 -> Hsync/Vsync reproduce it delayed exactly 2 clk.
REQ-034 Apply 4 vsync rising edges (TWINKLE_SHIFT=2), star_phase=0 -> phase=1, channel=3; after 64 edges frame_cnt wraps to 0.
REQ-035 star_on=1, display_on=0, star_color=3'b111 -> all channels 0.
REQ-036 Assert reset mid-frame with frame_cnt=9 -> next cycle frame_cnt=0, colours 0, Hsync/Vsync inactive.
